pattern_det_param: RTL and testbench

PATTERN_DET_PARAM -- requirements
Module: pattern_det_param

---
 rtl/pattern_det_param.sv | 134 +++++++++++++
 tb/tb_pattern_det_param.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_det_param.sv
// pattern_det_param: serial pattern detector with a run-time loadable pattern,
// overlapping/non-overlapping detection, a saturating match counter, and a
// fill indicator showing how many valid history bits are held.
// Optional feature: define PAT_DET_MASK_EN to add a per-bit compare mask
// (port mask_i) captured on the pattern-load strobe.
module pattern_det_param #(
  parameter int unsigned      PAT_W   = 5,
  parameter int unsigned      CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = 5'b10110
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       d_i,
  input  logic                       valid_i,
  input  logic [PAT_W-1:0]           pat_i,
`ifdef PAT_DET_MASK_EN
  input  logic [PAT_W-1:0]           mask_i,
`endif
  input  logic                       pat_load_i,
  input  logic                       overlap_i,
  input  logic                       cnt_clr_i,
  output logic                       pattern_o,
  output logic [CNT_W-1:0]           match_cnt_o,
  output logic [$clog2(PAT_W+1)-1:0] fill_o
);

  localparam int unsigned       FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // Detector occupancy: nothing held, partially filled, or a full window.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-1:0]  mask_q;
  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_q, fill_d, fill_adv;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pulse_q, pulse_d;
  logic              hit;

  // History after shifting in d_i; a one-bit window is simply the new bit.
  generate
    if (PAT_W == 1) begin : g_shift_one
      assign hist_shift = d_i;
    end else begin : g_shift_many
      assign hist_shift = {hist_q[PAT_W-2:0], d_i};
    end
  endgenerate

`ifdef PAT_DET_MASK_EN
  // Compare mask: captured from mask_i together with the pattern, all ones after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_q <= '1;
    end else if (pat_load_i) begin
      mask_q <= mask_i;
    end
  end
`else
  assign mask_q = '1;
`endif

  // Next-state logic: pattern load, history shift, match detection, counter.
  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    pat_d    = pat_q;
    fill_d   = fill_q;
    fill_adv = fill_q;
    cnt_d    = cnt_q;
    hit      = 1'b0;

    if (pat_load_i) begin
      // A load restarts detection; the bit on d_i is dropped even if valid.
      pat_d  = pat_i;
      hist_d = '0;
      fill_d = '0;
    end else if (valid_i) begin
      hist_d   = hist_shift;
      fill_adv = (state_q == ARMED) ? fill_q : fill_q + 1'b1;
      hit      = (fill_adv == FILL_FULL) && (((hist_shift ^ pat_q) & mask_q) == '0);
      // Non-overlapping mode forces a whole fresh window before the next match.
      fill_d   = (hit && !overlap_i) ? '0 : fill_adv;
    end

    if (fill_d == '0) begin
      state_d = IDLE;
    end else if (fill_d == FILL_FULL) begin
      state_d = ARMED;
    end else begin
      state_d = FILL;
    end

    // Clear wins over a same-edge increment; the count sticks at its maximum.
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end

    pulse_d = hit;
  end

  // State registers; reset reloads the power-up pattern and empties the window.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      pat_q   <= PAT_RST;
      fill_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pattern_o   = pulse_q;
  assign match_cnt_o = cnt_q;
  assign fill_o      = fill_q;

endmodule

// File: tb/tb_pattern_det_param.sv
// Testbench for pattern_det_param: vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
// Three instances: default (PAT_W=5, CNT_W=8), narrow counter (CNT_W=2),
// and single-bit pattern (PAT_W=1).
module tb_pattern_det_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d = 1'b0;
  logic       valid = 1'b0;
  logic       load = 1'b0;
  logic       ovl = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] pat5 = 5'b0;
  logic [0:0] pat1 = 1'b0;
`ifdef PAT_DET_MASK_EN
  logic [4:0] mask5 = 5'b11111;
  logic [0:0] mask1 = 1'b1;
`endif

  logic       pa, pc, pb;
  logic [7:0] ca;
  logic [1:0] cc;
  logic [3:0] cb;
  logic [2:0] fa, fc;
  logic [0:0] fb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_det_param dut_a (
    .clk(clk), .rst(rst), .d_i(d), .valid_i(valid), .pat_i(pat5),
`ifdef PAT_DET_MASK_EN
    .mask_i(mask5),
`endif
    .pat_load_i(load), .overlap_i(ovl), .cnt_clr_i(clr),
    .pattern_o(pa), .match_cnt_o(ca), .fill_o(fa)
  );

  pattern_det_param #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .d_i(d), .valid_i(valid), .pat_i(pat5),
`ifdef PAT_DET_MASK_EN
    .mask_i(mask5),
`endif
    .pat_load_i(load), .overlap_i(ovl), .cnt_clr_i(clr),
    .pattern_o(pc), .match_cnt_o(cc), .fill_o(fc)
  );

  pattern_det_param #(.PAT_W(1), .CNT_W(4), .PAT_RST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .d_i(d), .valid_i(valid), .pat_i(pat1),
`ifdef PAT_DET_MASK_EN
    .mask_i(mask1),
`endif
    .pat_load_i(load), .overlap_i(ovl), .cnt_clr_i(clr),
    .pattern_o(pb), .match_cnt_o(cb), .fill_o(fb)
  );

  // Reference model: queues hold the valid bits received since the last
  // restart (oldest first), trimmed to the pattern length.
  int         qa[$];
  int         qb[$];
  logic [4:0] m_pat5 = 5'b10110;
  logic [4:0] m_mask5 = 5'b11111;
  logic       m_pat1 = 1'b1;
  int         m_c8 = 0, m_c2 = 0, m_c1 = 0;
  bit         m_p5 = 0, m_p1 = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_update();
    bit ok;
    m_p5 = 0;
    m_p1 = 0;
    if (!rst) begin
      qa.delete(); qb.delete();
      m_pat5 = 5'b10110; m_mask5 = 5'b11111; m_pat1 = 1'b1;
      m_c8 = 0; m_c2 = 0; m_c1 = 0;
      return;
    end
    if (load) begin
      qa.delete(); qb.delete();
      m_pat5 = pat5; m_pat1 = pat1[0];
`ifdef PAT_DET_MASK_EN
      m_mask5 = mask5;
`endif
    end else if (valid) begin
      qa.push_back(int'(d));
      if (qa.size() > 5) void'(qa.pop_front());
      if (qa.size() == 5) begin
        ok = 1;
        for (int i = 0; i < 5; i++)
          if (m_mask5[4-i] && (qa[i] != int'(m_pat5[4-i]))) ok = 0;
        if (ok) begin
          m_p5 = 1;
          if (!ovl) qa.delete();
        end
      end
      qb.delete();
      qb.push_back(int'(d));
      if (int'(d) == int'(m_pat1)) begin
        m_p1 = 1;
        if (!ovl) qb.delete();
      end
    end
    if (clr) begin
      m_c8 = 0; m_c2 = 0; m_c1 = 0;
    end else begin
      if (m_p5 && m_c8 < 255) m_c8++;
      if (m_p5 && m_c2 < 3) m_c2++;
      if (m_p1 && m_c1 < 15) m_c1++;
    end
  endtask

  // One clock: drive inputs, let the edge happen, then compare all instances to the model.
  task automatic step(input bit r, input bit v, input bit dd, input bit ld, input bit ov, input bit cl);
    rst = r; valid = v; d = dd; load = ld; ovl = ov; clr = cl;
    @(posedge clk);
    model_update();
    #1;
    chk("mdl_p5", int'(pa), int'(m_p5));
    chk("mdl_cnt8", int'(ca), m_c8);
    chk("mdl_fill5", int'(fa), qa.size());
    chk("mdl_p5c", int'(pc), int'(m_p5));
    chk("mdl_cnt2", int'(cc), m_c2);
    chk("mdl_fill5c", int'(fc), qa.size());
    chk("mdl_p1", int'(pb), int'(m_p1));
    chk("mdl_cnt1", int'(cb), m_c1);
    chk("mdl_fill1", int'(fb), qb.size());
  endtask

  typedef struct {
    bit r, v, dd, ov, ep;
    int ec, ef;
  } vec_t;
  vec_t vt[$];

  initial begin
    logic [4:0]  b5;
    logic [16:0] s17;
    int          exp_cnt[5];
    int          m, k;

    // Stream 1,0,1,1,0,1,1,0 with overlap on, then off; fields r,v,d,ov,pulse,cnt,fill.
    vt.push_back('{0,0,0,1,0,0,0});
    vt.push_back('{0,0,0,1,0,0,0});
    vt.push_back('{1,1,1,1,0,0,1});
    vt.push_back('{1,1,0,1,0,0,2});
    vt.push_back('{1,1,1,1,0,0,3});
    vt.push_back('{1,1,1,1,0,0,4});
    vt.push_back('{1,1,0,1,1,1,5});
    vt.push_back('{1,1,1,1,0,1,5});
    vt.push_back('{1,1,1,1,0,1,5});
    vt.push_back('{1,1,0,1,1,2,5});
    vt.push_back('{0,0,0,0,0,0,0});
    vt.push_back('{1,1,1,0,0,0,1});
    vt.push_back('{1,1,0,0,0,0,2});
    vt.push_back('{1,1,1,0,0,0,3});
    vt.push_back('{1,1,1,0,0,0,4});
    vt.push_back('{1,1,0,0,1,1,0});
    vt.push_back('{1,1,1,0,0,1,1});
    vt.push_back('{1,1,1,0,0,1,2});
    vt.push_back('{1,1,0,0,0,1,3});

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].v, vt[i].dd, 1'b0, vt[i].ov, 1'b0);
      chk("tbl_p", int'(pa), int'(vt[i].ep));
      chk("tbl_cnt", int'(ca), vt[i].ec);
      chk("tbl_fill", int'(fa), vt[i].ef);
    end

    // Invalid gap cycles carrying d=1 must not disturb a partial match.
    step(0, 0, 0, 0, 1, 0);
    b5 = 5'b10110;
    for (int i = 4; i >= 0; i--) begin
      step(1, 1, b5[i], 0, 1, 0);
      chk("gap_p", int'(pa), (i == 0) ? 1 : 0);
      if (i != 0)
        for (int g = 0; g < 3; g++) begin
          step(1, 0, 1, 0, 1, 0);
          chk("gap_hold_p", int'(pa), 0);
          chk("gap_hold_fill", int'(fa), 5 - i);
        end
    end
    chk("gap_cnt", int'(ca), 1);

    // Pattern load mid-stream discards history and the bit on d.
    step(0, 0, 0, 0, 1, 0);
    b5 = 5'b10110;
    for (int i = 4; i >= 1; i--) begin
      step(1, 1, b5[i], 0, 1, 0);
      chk("load_pre_p", int'(pa), 0);
    end
    pat5 = 5'b00111;
    step(1, 1, 1, 1, 1, 0);
    chk("load_fill", int'(fa), 0);
    chk("load_p", int'(pa), 0);
    chk("load_cnt", int'(ca), 0);
    b5 = 5'b00111;
    for (int i = 4; i >= 0; i--) begin
      step(1, 1, b5[i], 0, 1, 0);
      chk("load_post_p", int'(pa), (i == 0) ? 1 : 0);
    end
    chk("load_post_cnt", int'(ca), 1);

    // Saturation of a 2-bit counter, then clear on the same edge as the 5th match.
    step(0, 0, 0, 0, 1, 0);
    s17 = 17'b10110110110110110;
    exp_cnt = '{1, 2, 3, 3, 0};
    m = 0;
    for (int i = 16; i >= 0; i--) begin
      k = 16 - i;
      step(1, 1, s17[i], 0, 1, (i == 0));
      chk("sat_p", int'(pc), (k == 4 || k == 7 || k == 10 || k == 13 || k == 16) ? 1 : 0);
      if (k == 4 || k == 7 || k == 10 || k == 13 || k == 16) begin
        chk("sat_cnt", int'(cc), exp_cnt[m]);
        m++;
      end
    end

    // One-bit pattern matches every equal bit even without overlap.
    step(0, 0, 0, 0, 0, 0);
    b5 = 5'b01101;
    for (int i = 3; i >= 0; i--) begin
      step(1, 1, b5[i], 0, 0, 0);
      chk("w1_p", int'(pb), int'(b5[i]));
    end
    chk("w1_cnt", int'(cb), 3);

    // Reset on the edge that would have completed the pattern.
    step(0, 0, 0, 0, 1, 0);
    b5 = 5'b10110;
    for (int i = 4; i >= 1; i--) step(1, 1, b5[i], 0, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    chk("rst_mid_p", int'(pa), 0);
    chk("rst_mid_fill", int'(fa), 0);
    step(1, 0, 0, 0, 1, 0);
    chk("rst_after_p", int'(pa), 0);

`ifdef PAT_DET_MASK_EN
    // Masked bit 2 is a don't-care; reset after four bits gives no pulse.
    pat5 = 5'b10110; mask5 = 5'b11011;
    step(1, 0, 0, 1, 0, 0);
    b5 = 5'b10110;
    for (int i = 4; i >= 0; i--) begin
      step(1, 1, b5[i], 0, 0, 0);
      chk("mask_a_p", int'(pa), (i == 0) ? 1 : 0);
    end
    b5 = 5'b10010;
    for (int i = 4; i >= 0; i--) begin
      step(1, 1, b5[i], 0, 0, 0);
      chk("mask_b_p", int'(pa), (i == 0) ? 1 : 0);
    end
    for (int i = 4; i >= 1; i--) step(1, 1, b5[i], 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("mask_rst_p", int'(pa), 0);
    step(1, 0, 0, 0, 0, 0);
    chk("mask_rst_after_p", int'(pa), 0);
    mask5 = 5'b11111;
`endif

    // Randomized run against the reference model.
    step(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      pat5 = 5'($urandom);
      pat1 = 1'($urandom);
`ifdef PAT_DET_MASK_EN
      mask5 = 5'($urandom);
`endif
      step(($urandom_range(99) != 0), ($urandom_range(3) != 0), 1'($urandom),
           ($urandom_range(49) == 0), 1'($urandom), ($urandom_range(39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
